// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode seven-segment scanner for a 16-bit signed value.
// The value is latched once per scan frame, so the display is never torn.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] din,
  input  logic               mode,
  output logic [3:0]         an,
  output logic [6:0]         seg,
  output logic               dp
);

  localparam int DATA_W = 16;
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]     presc_p0;
  logic [1:0]        idx_p0;
  logic [DATA_W-1:0] frame_p0;
  logic              neg_p0;
  logic              tick;
  logic              frame_tick;
  logic [3:0]        nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  // Two's-complement negate; -32768 maps to itself and is shown as 8000.
  function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] v);
    logic [DATA_W-1:0] u;
    u = v;
    return ~u + DATA_W'(1);
  endfunction

  assign tick       = (presc_p0 == PMAX);
  assign frame_tick = tick && (idx_p0 == 2'd3);
  assign nib        = frame_p0[{idx_p0, 2'b00} +: 4];

  // Stage p0: prescaler, digit index and frame capture
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_p0 <= '0;
      idx_p0   <= '0;
      frame_p0 <= '0;
      neg_p0   <= 1'b0;
    end else begin
      presc_p0 <= tick ? '0 : presc_p0 + PW'(1);
      if (tick)
        idx_p0 <= idx_p0 + 2'd1;
      if (frame_tick) begin
        if (mode && din[DATA_W-1]) begin
          frame_p0 <= magnitude(din);
          neg_p0   <= 1'b1;
        end else begin
          frame_p0 <= din;
          neg_p0   <= 1'b0;
        end
      end
    end
  end

  // Stage p1: registered digit drive, an and seg switch on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= ~(4'b0001 << idx_p0);
      seg <= decode(nib);
      dp  <= ~(neg_p0 && (idx_p0 == 2'd3));
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random traffic,
// checked every cycle against a cycle-count based display model.
module tb_seg7_scan_driver;

  localparam int D = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [15:0] din;
  logic               mode;
  logic [3:0]         an;
  logic [6:0]         seg;
  logic               dp;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // model: m = edges since reset release, captured value and sign flag
  int          m = 0;
  logic [15:0] mframe = 16'h0;
  bit          mneg = 1'b0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  logic [6:0] segtab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg7_scan_driver #(.REFRESH_DIV(D)) dut (
    .clk (clk),
    .rst (rst),
    .din (din),
    .mode(mode),
    .an  (an),
    .seg (seg),
    .dp  (dp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one clock edge: advance the model with pre-edge inputs, then compare
  task automatic step();
    logic [15:0] d;
    logic        md;
    logic        r;
    int          k;
    int          v;
    d  = din;
    md = mode;
    r  = rst;
    @(posedge clk);
    #1;
    if (r) begin
      m = 0; mframe = 16'h0; mneg = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
    end else begin
      k     = (m / D) % 4;
      e_an  = 4'hF ^ (4'd1 << k);
      e_seg = segtab[(mframe >> (4 * k)) & 16'hF];
      e_dp  = !(mneg && k == 3);
      m++;
      if (m % (4 * D) == 0) begin
        v = int'($signed(d));
        if (md && v < 0) begin
          mframe = 16'(-v);
          mneg   = 1'b1;
        end else begin
          mframe = d;
          mneg   = 1'b0;
        end
      end
    end
    chk("an", 16'(an), 16'(e_an));
    chk("seg", 16'(seg), 16'(e_seg));
    chk("dp", 16'(dp), 16'(e_dp));
    chk("onehot", 16'($countones(~an)), r ? 16'd0 : 16'd1);
  endtask

  // step at least once, then until m mod frame equals target (bounded)
  task automatic seek(input int target);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while ((m % (4 * D)) != target && n < 64);
    chk("seek_bound", 16'(m % (4 * D)), 16'(target));
  endtask

  logic [6:0] rawexp [4] = '{7'b0001110, 7'b0010010, 7'b0001000, 7'b1111001};

  initial begin
    rst = 1'b1; din = 16'sh0; mode = 1'b0;

    // reset held three cycles
    repeat (3) step();
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_dp", 16'(dp), 16'h1);

    // release: 0000 shown from digit 0
    rst = 1'b0;
    step();
    chk("rel_an", 16'(an), 16'hE);
    chk("rel_seg", 16'(seg), 16'h40);
    repeat (3) step();
    step();
    chk("rel_an1", 16'(an), 16'hD);

    // raw hex 1A5F
    din = 16'sh1A5F; mode = 1'b0;
    seek(0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("raw_an", 16'(an), 16'(4'hF ^ (4'd1 << i)));
      chk("raw_seg", 16'(seg), 16'(rawexp[i]));
      chk("raw_dp", 16'(dp), 16'h1);
      repeat (D - 1) step();
    end

    // magnitude of -10 and of -32768
    din = 16'shFFF6; mode = 1'b1;
    seek(0);
    seek(0);
    din = -16'sd32768;
    seek(0);
    step();
    chk("min_d0", 16'(seg), 16'h40);
    seek(13);
    chk("min_d3", 16'(seg), 16'h00);
    chk("min_dp", 16'(dp), 16'h0);

    // tear-free capture
    din = 16'sh1111; mode = 1'b0;
    seek(0);
    seek(5);
    din = 16'sh2222;
    seek(13);
    chk("tear_old", 16'(seg), 16'h79);
    seek(0);
    step();
    chk("tear_new", 16'(seg), 16'h24);

    // mid-scan reset while digit 2 lit
    seek(9);
    chk("mid_an2", 16'(an), 16'hB);
    rst = 1'b1;
    step();
    chk("mid_rst", 16'(an), 16'hF);
    rst = 1'b0;
    step();
    chk("mid_an0", 16'(an), 16'hE);
    chk("mid_seg0", 16'(seg), 16'h40);
    repeat (20) step();

    // mode toggled mid-frame with din = FFFF
    din = 16'shFFFF; mode = 1'b0;
    seek(0);
    seek(6);
    mode = 1'b1;
    seek(13);
    chk("mode_old", 16'(seg), 16'h0E);
    seek(0);
    step();
    chk("mode_new0", 16'(seg), 16'h79);
    seek(13);
    chk("mode_new3", 16'(seg), 16'h40);
    chk("mode_dp", 16'(dp), 16'h0);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) din = $signed(16'($urandom));
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      rst = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Downstream display stage for the processor's 16-bit signed `out` bus. The block captures the value once per scan frame and time-multiplexes it onto a 4-digit common-anode seven-segment display as four hex nibbles. In magnitude mode it shows |value| and lights the leftmost decimal point for negative values. Capture happens only at frame boundaries, so a changing `out` never produces a torn display.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit. Legal range ≥ 2.
- `clk`  input  1  system clock, shared with the processor.
- `rst`  input  1  synchronous, active-high reset.
- `din`  input  16  signed value to display; connects to the processor `out`.
- `mode`  input  1  0 = raw two's-complement hex, 1 = sign-magnitude hex.
- `an`  output  4  digit enables, active-low; `an[0]` is the rightmost, least-significant digit.
- `seg`  output  7  segment cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- `dp`  output  1  decimal point, active-low.

## Operation
- Internal state:
  - `presc`: 0..REFRESH_DIV-1, width $clog2(REFRESH_DIV).
  - `idx`: 2-bit digit index.
  - `frame`: 16-bit captured display value.
  - `neg`: 1-bit captured sign flag.
  - `an`, `seg`, `dp`: registered outputs.
- Prescaler: increments every cycle. It wraps to 0 when it equals REFRESH_DIV-1; that cycle is a "tick".
- Digit index: on each tick, `idx` advances 0→1→2→3→0.
- Frame capture (the "frame tick") happens on the tick where `idx`==3, i.e. the same edge that `idx` returns to 0. `din` and `mode` are sampled only on that edge.
  - `mode`=0: `frame` <= `din`; `neg` <= 0.
  - `mode`=1, `din[15]`=0: `frame` <= `din`; `neg` <= 0.
  - `mode`=1, `din[15]`=1: `frame` <= (~`din` + 1) truncated to 16 bits; `neg` <= 1. For -32768 (0x8000) this yields 0x8000 with `neg`=1.
- Output registers update every cycle from the current `idx`/`frame`/`neg`:
  - `an` <= ~(4'b0001 << `idx`).
  - `seg` <= decode(`frame`[4·`idx`+3 : 4·`idx`]).
  - `dp` <= ~(`neg` && `idx`==3).
- Decode table, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Reset values:
  - outputs: `an`=1111 (all digits off), `seg`=1111111, `dp`=1.
  - state: `presc`=0, `idx`=0, `frame`=0, `neg`=0.
- Reset asserted mid-scan: everything returns to reset values on the next edge, and the display blanks.

## Timing
- Outputs are registered and lag `idx`/`frame` by exactly one cycle.
- First edge with `rst` low: outputs become `an`=1110 with `seg` decoding digit 0 of `frame`=0, so the display shows "0000" for the entire first frame.
- Each digit stays lit for REFRESH_DIV cycles. A full frame is 4·REFRESH_DIV cycles.
- `din` latency:
  - A value present on the frame-tick edge appears on digit 0 one cycle later.
  - It appears on digit k at 1 + k·REFRESH_DIV cycles after that edge.
  - Worst case from a `din` change to first display is 4·REFRESH_DIV + 1 cycles.
- `din`/`mode` changes between frame ticks are ignored.
- Exactly one `an` bit is low at any time outside reset. Digit switches are glitch-free because `an` and `seg` update on the same edge.

## Test plan
All scenarios use REFRESH_DIV=4 (frame = 16 cycles).

- **Reset:** hold `rst` 3 cycles → `an`=1111, `seg`=1111111, `dp`=1. Release → `an`=1110, `seg`=1000000 for 4 cycles, then `an`=1101.
- **Raw hex:** `din`=0x1A5F, `mode`=0, held through a frame tick. Next frame shows, over 4 cycles each:
  - `an`=1110, `seg`=0001110 (F)
  - `an`=1101, `seg`=0010010 (5)
  - `an`=1011, `seg`=0001000 (A)
  - `an`=0111, `seg`=1111001 (1)
  - `dp`=1 throughout.
- **Magnitude negative:** `din`=0xFFF6 (-10), `mode`=1 → digits show 000A; `dp`=0 only while `an`=0111. Boundary case: `din`=0x8000, `mode`=1 → digits 8000 with `dp`=0 on digit 3.
- **Tear-free capture:** change `din` from 0x1111 to 0x2222 while digit 1 is lit → all four digits stay 1 until the frame tick, then the next frame shows all 2.
- **Mid-scan reset:** assert `rst` while `an`=1011 → next edge `an`=1111. After release the scan restarts at digit 0 and shows 0000 regardless of the previous `din`.
- **Mode sampling:** toggle `mode` mid-frame with `din`=0xFFFF → the display stays FFFF until the frame tick, then shows 0001 with `dp`=0 on digit 3.
